// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes (same encoding
// as the decoder), FSM state encoding and the default access timeout.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'd0,
    LDST_H  = 3'd1,
    LDST_W  = 3'd2,
    LDST_BU = 3'd4,
    LDST_HU = 3'd5
  } ldst_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-memory port: req/gnt request phase followed by a single rvalid response.
interface riscv_lsu_if;

  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store byte enables and lane replication, load
// extraction with sign/zero extension, and the illegal-access flag.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata_i[{offset_i, 3'b000} +: 8];
  assign rhalf = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;

    case (size_i)
      LDST_B, LDST_BU: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_o       = 4'b0011 << offset_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = offset_i[0];
      end
      LDST_W: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |offset_i;
      end
      default: misalign_o = 1'b1;  // sizes 3, 6, 7 are not encodable accesses
    endcase

    // Loads always fetch the whole word; extraction happens on the way back.
    if (!we_i) begin
      be_o = 4'b1111;
    end

    case (size_i)
      LDST_B:  rdata_o = {{24{rbyte[7]}}, rbyte};
      LDST_BU: rdata_o = {24'h0, rbyte};
      LDST_H:  rdata_o = {{16{rhalf[15]}}, rhalf};
      LDST_HU: rdata_o = {16'h0, rhalf};
      LDST_W:  rdata_o = rdata_i;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access at a time, stalls the core until the
// memory response (or a timeout) lands, then presents the load result in DONE.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lsu_req_i,
  input  logic             lsu_we_i,
  input  logic [2:0]       lsu_size_i,
  input  logic [31:0]      lsu_addr_i,
  input  logic [31:0]      lsu_wdata_i,
  output logic [31:0]      lsu_rdata_o,
  output logic             lsu_stall_req_o,
  output logic             lsu_err_o,
  riscv_lsu_if.master      data_if
);

  localparam int unsigned    CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam bit             TO_EN     = (TIMEOUT != 0);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      rdata_q, rdata_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;
  logic        mem_req;
  logic        timeout;

  riscv_lsu_align u_align (
    .we_i       (lsu_we_i),
    .size_i     (lsu_size_i),
    .offset_i   (lsu_addr_i[1:0]),
    .wdata_i    (lsu_wdata_i),
    .rdata_i    (data_if.data_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  // The limit is reached on the TIMEOUT-th cycle spent in REQ+RESP.
  assign timeout = TO_EN && (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_d         = state_q;
    cnt_d           = '0;
    rdata_d         = rdata_q;
    mem_req         = 1'b0;
    lsu_stall_req_o = 1'b0;
    lsu_err_o       = 1'b0;

    unique case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (al_misalign) begin
            lsu_err_o = 1'b1;
          end else begin
            mem_req         = 1'b1;
            lsu_stall_req_o = 1'b1;
            state_d         = data_if.data_gnt ? LSU_RESP : LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        mem_req         = 1'b1;
        lsu_stall_req_o = 1'b1;
        if (timeout) begin
          lsu_err_o = 1'b1;
          rdata_d   = 32'h0;
          state_d   = LSU_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (data_if.data_gnt) state_d = LSU_RESP;
        end
      end
      LSU_RESP: begin
        lsu_stall_req_o = 1'b1;
        if (timeout) begin
          lsu_err_o = 1'b1;
          rdata_d   = 32'h0;
          state_d   = LSU_DONE;
        end else if (data_if.data_rvalid) begin
          rdata_d = lsu_we_i ? 32'h0 : al_rdata;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;  // the core advances now; its request is not ours yet
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign lsu_rdata_o = (state_q == LSU_DONE) ? rdata_q : 32'h0;

  assign data_if.data_req   = mem_req;
  assign data_if.data_we    = mem_req & lsu_we_i;
  assign data_if.data_be    = mem_req ? al_be : 4'b0000;
  assign data_if.data_addr  = mem_req ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
  assign data_if.data_wdata = (mem_req && lsu_we_i) ? al_wdata : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a cycle-level expectation model derived from
// the access timing rules, checked every cycle, plus literal spot values.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam int unsigned TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'd0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        lsu_err;

  riscv_lsu_if mem ();

  riscv_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_wdata_i     (lsu_wdata),
    .lsu_rdata_o     (lsu_rdata),
    .lsu_stall_req_o (lsu_stall),
    .lsu_err_o       (lsu_err),
    .data_if         (mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic        stall;
    logic        err;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_wdata;
    logic        chk_rdata;
  } exp_t;

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          g;          // cycle of gnt relative to the request cycle
    int          r;          // cycles from gnt to rvalid
    bit          stray;      // extra rvalid in DONE and the idle cycle after
    bit          lit_rd;
    logic [31:0] lit_rdata;
    int          lit_stall;
    int          lit_reqs;
    int          lit_err_k;
    bit          lit_st;
    logic [3:0]  lit_be;
    logic [31:0] lit_wdata;
    logic [31:0] lit_addr;
  } scen_t;

  exp_t exp_c = '0;
  bit   chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  function automatic int m_bytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
    int n = m_bytes(size);
    if (n == 0) return 1'b0;
    return (addr % n) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] word);
    int unsigned v;
    int unsigned lane = addr % 4;
    case (size)
      3'd0, 3'd4: begin
        v = (word >> (8 * lane)) & 32'hFF;
        if (size == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (lane / 2))) & 32'hFFFF;
        if (size == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] size, input logic [31:0] addr);
    int unsigned lane = addr % 4;
    int unsigned v;
    if (!we) return 4'hF;
    case (m_bytes(size))
      1:       v = 1 << lane;
      2:       v = 3 << lane;
      default: v = 15;
    endcase
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] wdata);
    case (m_bytes(size))
      1:       return (wdata & 32'hFF) * 32'h0101_0101;
      2:       return (wdata & 32'hFFFF) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  function automatic bit m_timeout(input scen_t s);
    return m_legal(s.size, s.addr) && !(s.g + s.r < int'(TB_TIMEOUT));
  endfunction

  // Cycle index (from the request) of the DONE cycle; 0 for rejected accesses.
  function automatic int m_done(input scen_t s);
    if (!m_legal(s.size, s.addr)) return 0;
    if (m_timeout(s)) return int'(TB_TIMEOUT) + 1;
    return s.g + s.r + 1;
  endfunction

  function automatic exp_t m_cycle(input scen_t s, input int k);
    exp_t e = '0;
    int   done = m_done(s);
    bit   to = m_timeout(s);
    if (!m_legal(s.size, s.addr)) begin
      e.err = (k == 0);
      return e;
    end
    if (k > done) return e;
    e.stall     = (k < done);
    e.req       = (k <= s.g) && (k < done);
    e.we        = e.req && s.we;
    e.be        = e.req ? m_be(s.we, s.size, s.addr) : 4'h0;
    e.addr      = e.req ? (s.addr & ~32'h3) : 32'h0;
    e.wdata     = e.we ? m_wdata(s.size, s.wdata) : 32'h0;
    e.chk_wdata = e.we;
    e.err       = to && (k == int'(TB_TIMEOUT));
    e.chk_rdata = (k == done);
    e.rdata     = (to || s.we) ? 32'h0 : m_load(s.size, s.addr, s.word);
    return e;
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(lsu_stall), 32'(exp_c.stall));
      check("err", 32'(lsu_err), 32'(exp_c.err));
      check("data_req", 32'(mem.data_req), 32'(exp_c.req));
      check("data_we", 32'(mem.data_we), 32'(exp_c.we));
      check("data_be", 32'(mem.data_be), 32'(exp_c.be));
      check("data_addr", mem.data_addr, exp_c.addr);
      if (exp_c.chk_wdata) check("data_wdata", mem.data_wdata, exp_c.wdata);
      if (exp_c.chk_rdata) check("rdata", lsu_rdata, exp_c.rdata);
    end
  end

  // ---------------- stimulus ----------------
  function automatic scen_t sc(input string name, input bit we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] word, input int g, input int r);
    scen_t s;
    s.name = name; s.we = we; s.size = size; s.addr = addr; s.wdata = wdata;
    s.word = word; s.g = g; s.r = r; s.stray = 1'b0;
    s.lit_rd = 1'b0; s.lit_rdata = 32'h0; s.lit_stall = -1; s.lit_reqs = -1;
    s.lit_err_k = -1; s.lit_st = 1'b0; s.lit_be = 4'h0; s.lit_wdata = 32'h0;
    s.lit_addr = 32'h0;
    return s;
  endfunction

  task automatic run(input scen_t s);
    int done = m_done(s);
    int stalls = 0;
    int reqs = 0;
    int err_k = -1;
    for (int k = 0; k <= done + 1; k++) begin
      @(posedge clk); #1;
      if (k <= done) begin
        lsu_req = 1'b1; lsu_we = s.we; lsu_size = s.size;
        lsu_addr = s.addr; lsu_wdata = s.wdata;
      end else begin
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
      end
      mem.data_gnt    = (k == s.g);
      mem.data_rvalid = (k == s.g + s.r) || (s.stray && k >= done);
      mem.data_rdata  = (k == s.g + s.r) ? s.word : 32'h5A5A_5A5A;
      exp_c = m_cycle(s, k);
      #1;
      if (lsu_stall) stalls++;
      if (mem.data_req) reqs++;
      if (lsu_err && err_k < 0) err_k = k;
      if (s.lit_st && k == 0) begin
        check({s.name, "_be"}, 32'(mem.data_be), 32'(s.lit_be));
        check({s.name, "_wdata"}, mem.data_wdata, s.lit_wdata);
        check({s.name, "_addr"}, mem.data_addr, s.lit_addr);
        check({s.name, "_we"}, 32'(mem.data_we), 32'd1);
      end
      if (s.lit_rd && k == done) check({s.name, "_rdata_lit"}, lsu_rdata, s.lit_rdata);
    end
    mem.data_gnt = 1'b0;
    mem.data_rvalid = 1'b0;
    if (s.lit_stall >= 0) check({s.name, "_stall_cycles"}, stalls, s.lit_stall);
    if (s.lit_reqs >= 0) check({s.name, "_req_cycles"}, reqs, s.lit_reqs);
    if (s.lit_err_k >= 0) check({s.name, "_err_cycle"}, err_k, s.lit_err_k);
  endtask

  scen_t list[$];

  initial begin
    scen_t s;
    mem.data_gnt = 1'b0; mem.data_rvalid = 1'b0; mem.data_rdata = 32'h0;

    // Model pins against hand-computed values.
    check("model_lb", m_load(3'd0, 32'h103, 32'h80FF_1234), 32'hFFFF_FF80);
    check("model_lbu", m_load(3'd4, 32'h103, 32'h80FF_1234), 32'h0000_0080);
    check("model_sh_wdata", m_wdata(3'd1, 32'h0000_ABCD), 32'hABCD_ABCD);

    // Reset state: every output 0.
    exp_c = '0; exp_c.chk_rdata = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;

    s = sc("lw", 0, LDST_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
    s.lit_rd = 1; s.lit_rdata = 32'hDEAD_BEEF; s.lit_stall = 2; list.push_back(s);
    s = sc("lb", 0, LDST_B, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
    s.lit_rd = 1; s.lit_rdata = 32'hFFFF_FF80; s.stray = 1; list.push_back(s);
    s = sc("lbu", 0, LDST_BU, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
    s.lit_rd = 1; s.lit_rdata = 32'h0000_0080; list.push_back(s);
    s = sc("sh", 1, LDST_H, 32'h102, 32'h0000_ABCD, 32'h0, 0, 1);
    s.lit_st = 1; s.lit_be = 4'b1100; s.lit_wdata = 32'hABCD_ABCD; s.lit_addr = 32'h100;
    s.lit_rd = 1; s.lit_rdata = 32'h0; list.push_back(s);
    s = sc("lw_mis", 0, LDST_W, 32'h101, 32'h0, 32'h0, -1, 0);
    s.lit_stall = 0; s.lit_reqs = 0; s.lit_err_k = 0; list.push_back(s);
    s = sc("size3", 0, 3'd3, 32'h100, 32'h0, 32'h0, -1, 0);
    s.lit_stall = 0; s.lit_reqs = 0; s.lit_err_k = 0; list.push_back(s);
    s = sc("size6", 1, 3'd6, 32'h100, 32'h0, 32'h0, -1, 0); list.push_back(s);
    s = sc("size7", 0, 3'd7, 32'h104, 32'h0, 32'h0, -1, 0); list.push_back(s);
    s = sc("lh_mis", 0, LDST_H, 32'h101, 32'h0, 32'h0, -1, 0); list.push_back(s);
    s = sc("lh", 0, LDST_H, 32'h102, 32'h0, 32'h8001_7FFF, 1, 1);
    s.lit_rd = 1; s.lit_rdata = 32'hFFFF_8001; list.push_back(s);
    s = sc("lhu", 0, LDST_HU, 32'h100, 32'h0, 32'h1234_F00D, 0, 3);
    s.lit_rd = 1; s.lit_rdata = 32'h0000_F00D; s.stray = 1; list.push_back(s);
    s = sc("sb", 1, LDST_B, 32'h101, 32'h1234_5678, 32'h0, 2, 1);
    s.lit_st = 1; s.lit_be = 4'b0010; s.lit_wdata = 32'h7878_7878; s.lit_addr = 32'h100;
    list.push_back(s);
    s = sc("sw", 1, LDST_W, 32'h104, 32'hCAFE_F00D, 32'h0, 0, 2);
    s.lit_st = 1; s.lit_be = 4'b1111; s.lit_wdata = 32'hCAFE_F00D; s.lit_addr = 32'h104;
    list.push_back(s);
    s = sc("lw_gnt3", 0, LDST_W, 32'h200, 32'h0, 32'h1357_9BDF, 3, 2);
    s.lit_stall = 6; list.push_back(s);
    s = sc("to_nognt", 0, LDST_W, 32'h300, 32'h0, 32'h0, 1000, 1);
    s.lit_stall = 17; s.lit_err_k = 16; s.lit_rd = 1; s.lit_rdata = 32'h0; list.push_back(s);
    s = sc("to_norvalid", 0, LDST_B, 32'h301, 32'h0, 32'h0, 0, 1000);
    s.lit_stall = 17; s.lit_err_k = 16; list.push_back(s);

    foreach (list[i]) run(list[i]);

    // Reset while in RESP, then a stray rvalid must be ignored.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = 32'h500;
    mem.data_gnt = 1'b1;
    exp_c = '0; exp_c.stall = 1; exp_c.req = 1; exp_c.be = 4'hF; exp_c.addr = 32'h500;
    @(posedge clk); #1;
    mem.data_gnt = 1'b0;
    exp_c = '0; exp_c.stall = 1;
    #2;
    rst_n = 1'b0; lsu_req = 1'b0;
    exp_c = '0; exp_c.chk_rdata = 1'b1;
    #1;
    check("rst_mid_stall", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem.data_rvalid = 1'b1; mem.data_rdata = 32'hFFFF_FFFF;
    end
    @(posedge clk); #1; mem.data_rvalid = 1'b0;

    s = sc("lw_post_rst", 0, LDST_W, 32'h400, 32'h0, 32'h0BAD_F00D, 0, 1);
    s.lit_rd = 1; s.lit_rdata = 32'h0BAD_F00D; s.lit_stall = 2;
    run(s);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the instruction decoder/ALU stage and the data memory. It accepts one memory access at a time from the core and drives a req/gnt/rvalid data-memory port. For stores it aligns data and byte enables; for loads it extracts, sign-extends or zero-extends the result. While an access is outstanding it stalls the core.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in REQ+RESP before the access is aborted; 0 disables the timeout.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `lsu_req_i` in 1: access request; the decoder's mem_req output.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_size_i` in 3: `LDST_B`=0, `LDST_H`=1, `LDST_W`=2, `LDST_BU`=4, `LDST_HU`=5.
- `lsu_addr_i` in 32: byte address from the ALU.
- `lsu_wdata_i` in 32: store data from rs2.
- `lsu_rdata_o` out 32: extended load result, valid in DONE.
- `lsu_stall_req_o` out 1: core must hold all lsu_* inputs stable while this is 1.
- `lsu_err_o` out 1: one-cycle pulse for misaligned access, illegal size, or timeout.
- `data_req_o` out 1: memory request.
- `data_we_o` out 1: memory write enable.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word address `{lsu_addr_i[31:2],2'b00}`.
- `data_wdata_o` out 32: lane-replicated store data.
- `data_gnt_i` in 1: memory accepted the request.
- `data_rvalid_i` in 1: response or write acknowledge.
- `data_rdata_i` in 32: read word.

## Operation
- FSM states are IDLE, REQ, RESP, DONE. Reset enters IDLE with every output 0 and the timeout counter at 0.
- **IDLE.** When `lsu_req_i` is high and the access is legal:
  - `data_req_o`=1 and `lsu_stall_req_o`=1, both combinational.
  - If `data_gnt_i` is high, go to RESP; otherwise go to REQ.
- **IDLE, illegal access.** When `lsu_req_i` is high and the access is illegal:
  - `lsu_err_o`=1 and stall=0.
  - No memory request is made and the state stays IDLE.
- **Illegal access definition:**
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - Size 3, 6 or 7.
- **REQ.** `data_req_o`=1 and stall=1. On `data_gnt_i`, go to RESP.
- **RESP.**
  - `data_req_o`=0 and stall=1.
  - On `data_rvalid_i`, register the extended load data (or 0 for a store) and go to DONE.
- **DONE.**
  - stall=0 and `lsu_rdata_o` is valid.
  - Unconditionally return to IDLE. `lsu_req_i` is ignored in this cycle, because the core is advancing.
- **Timeout.** The counter increments every cycle in REQ or RESP and clears on entry to IDLE/DONE. When it reaches `TIMEOUT`:
  - Pulse `lsu_err_o`.
  - Go to DONE with `lsu_rdata_o`=0.
- **Store alignment:**
  - B: `be`=`4'b0001<<addr[1:0]`, wdata = `{4{wdata[7:0]}}`.
  - H: `be`=`4'b0011<<addr[1:0]`, wdata = `{2{wdata[15:0]}}`.
  - W: `be`=`4'b1111`, wdata passed through.
- **Loads:** `be`=`4'b1111`.
  - Extract byte `addr[1:0]` or halfword `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
- `data_rvalid_i` in IDLE or DONE is ignored.
- `data_be_o`, `data_we_o`, `data_addr_o` and `data_wdata_o` are valid whenever `data_req_o`=1, and 0 otherwise.

## Timing
- Best case: request in cycle 0 with gnt in cycle 0, rvalid in cycle 1.
  - DONE is in cycle 2, so stall is high in cycles 0–1.
  - `lsu_rdata_o` is valid in cycle 2.
- Each gnt-wait cycle or rvalid-wait cycle adds one stall cycle.
- Misaligned/illegal access: zero stall cycles; `lsu_err_o` is high in the same cycle as the request.
- Asynchronous reset mid-access:
  - Immediate return to IDLE, all outputs 0, counter cleared.
  - Any later rvalid is ignored.
- A single response is accepted per request. Outstanding requests >1 are not supported.

## Structure
- Shared package/defines file: `LDST_*` size codes (identical to the decoder's), LSU state encoding, and the default `TIMEOUT`.
- Sub-module `riscv_lsu_align`, purely combinational, generates `be`, replicated wdata, the load extract/extend result, and the misalign flag.
- The top module holds the FSM, the timeout counter and the rdata register.

## Test plan
- **LW.** LW at 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF. Expect `lsu_rdata_o`=0xDEADBEEF in cycle 2 and stall high in exactly cycles 0–1.
- **LB / LBU.** LB at 0x103 with word 0x80FF_1234. Expect result 0xFFFFFF80. LBU at the same address gives 0x00000080.
- **SH.** SH at 0x102 with wdata 0x0000ABCD. Expect `be`=1100, `data_wdata_o`=0xABCDABCD, `data_addr_o`=0x100 and `we`=1.
- **Misaligned LW.** LW at 0x101. Expect `lsu_err_o`=1 in the same cycle, stall=0 and `data_req_o` never asserted. Size 3 produces the same response.
- **gnt delay then timeout.** gnt delayed 3 cycles, then rvalid 2 cycles later: stall lasts 6 cycles. Separately, with `TIMEOUT`=16 and no gnt, expect an error pulse after 16 cycles, then DONE, then IDLE.
- **Reset during RESP.** Assert reset in RESP, release it, then drive a stray rvalid. Expect the state to stay IDLE and all outputs 0.
